// File: rtl/count_sequencer.sv
// count_sequencer: button conditioning, start/pause/hold run control and
// display scan timing for the 0-9999 BCD counter. All outputs are registered
// and everything runs in the single clk domain.
module count_sequencer #(
  parameter int TICK_DIV   = 5000000,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 500000,
  parameter bit WRAP       = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       at_max,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] digit_sel,
  output logic [3:0] an
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Button vector order: bit 0 start, bit 1 stop, bit 2 clear.
  logic [2:0]       btn_raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       deb_lvl;
  logic [2:0]       deb_lvl_q;
  logic [2:0]       ev;
  logic [DEB_W-1:0] deb_cnt [3];

  logic             ev_start;
  logic             ev_stop;
  logic             ev_clear;

  state_t           state_q;
  state_t           state_d;
  logic [TICK_W-1:0] presc_q;
  logic [TICK_W-1:0] presc_d;
  logic             step;
  logic             cnt_en_d;
  logic             cnt_clr_d;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_inc;

  assign btn_raw   = {btn_clear, btn_stop, btn_start};
  assign ev_start  = ev[0];
  assign ev_stop   = ev[1];
  assign ev_clear  = ev[2];
  assign digit_inc = digit_sel + 2'd1;

  // Two-flop synchronizer for the asynchronous push-buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_lvl[i] <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level becomes a one-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl_q <= '0;
      ev        <= '0;
    end else begin
      deb_lvl_q <= deb_lvl;
      ev        <= deb_lvl & ~deb_lvl_q;
    end
  end

  // Next state, strobes and prescaler; clear > stop > start, clear beats a step
  always_comb begin
    state_d   = state_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    step      = (state_q == RUN) && (presc_q == TICK_LAST);

    if (ev_clear) begin
      state_d   = IDLE;
      cnt_clr_d = 1'b1;
    end else if (ev_stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (ev_start) begin
      if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
    end

    if (step && state_d == RUN) begin
      if (at_max && !WRAP) state_d = HOLD;
      else                 cnt_en_d = 1'b1;
    end

    // A state change restarts the period so a resume gets a full TICK_DIV
    if (state_q != RUN || state_d != state_q || presc_q == TICK_LAST)
      presc_d = '0;
    else
      presc_d = presc_q + TICK_W'(1);
  end

  // State register with registered run-control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_en  <= cnt_en_d;
      cnt_clr <= cnt_clr_d;
      running <= (state_d == RUN);
    end
  end

  // Free-running display scan, independent of run state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
      an        <= 4'b1110;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= digit_inc;
      an        <= ~(4'b0001 << digit_inc);
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

endmodule
